// File: rtl/fir_serial_ctrl.sv
// Sequencer for a full-serial FIR: one delay-line RAM, one coefficient
// ROM and one MAC. It zero-fills the delay line after reset, then takes
// one sample per strobe, writes it, walks all taps and pulses y_valid.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   x_vld/x_data  sample strobe and data (the source cannot stall)
//   x_rdy, busy   status: IDLE / not IDLE
//   dl_we/waddr/wdata  delay-line write port
//   dl_re/raddr   delay-line read port (data valid next cycle)
//   coef_addr     coefficient ROM address, shares dl_re timing
//   mac_en/first/last  MAC control aligned to the read data
//   y_valid       MAC result is valid (1-cycle pulse)
//   drop_cnt      strobes lost outside IDLE, saturating
module fir_serial_ctrl #(
    parameter int TAPS = 16,
    parameter int DW   = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        x_vld,
    input  logic [DW-1:0]               x_data,
    output logic                        x_rdy,
    output logic                        dl_we,
    output logic [$clog2(TAPS)-1:0]     dl_waddr,
    output logic [DW-1:0]               dl_wdata,
    output logic                        dl_re,
    output logic [$clog2(TAPS)-1:0]     dl_raddr,
    output logic [$clog2(TAPS)-1:0]     coef_addr,
    output logic                        mac_en,
    output logic                        mac_first,
    output logic                        mac_last,
    output logic                        y_valid,
    output logic                        busy,
    output logic [15:0]                 drop_cnt
);

    localparam int AW = $clog2(TAPS);
    localparam logic [AW-1:0] LAST = AW'(TAPS - 1);

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WRITE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_idx_q, clr_idx_d;
    logic [AW-1:0]   k_q, k_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [15:0]     drop_q, drop_d;

    logic            x_rdy_q, x_rdy_d;
    logic            busy_q, busy_d;
    logic            we_q, we_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            re_q, re_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [AW-1:0]   coef_q, coef_d;
    logic            men_q, men_d;
    logic            mfirst_q, mfirst_d;
    logic            mlast_q, mlast_d;
    logic            yv_q, yv_d;

    // Newest sample sits at wr_ptr; tap k reads k samples back,
    // wrapping without a modulo so TAPS need not be a power of two.
    function automatic logic [AW-1:0] tap_addr(
        input logic [AW-1:0] wp,
        input logic [AW-1:0] k
    );
        logic [AW:0] wrapped;
        wrapped = {1'b0, wp} + (AW+1)'(TAPS) - {1'b0, k};
        if (wp >= k) begin
            tap_addr = wp - k;
        end else begin
            tap_addr = wrapped[AW-1:0];
        end
    endfunction

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        k_d       = k_q;
        wr_ptr_d  = wr_ptr_q;
        drop_d    = drop_q;
        x_rdy_d   = 1'b0;
        busy_d    = 1'b1;
        we_d      = 1'b0;
        waddr_d   = '0;
        wdata_d   = '0;
        re_d      = 1'b0;
        raddr_d   = '0;
        coef_d    = '0;
        yv_d      = 1'b0;

        // MAC control is the read strobe delayed by the RAM latency.
        men_d    = re_q;
        mfirst_d = re_q && (coef_q == '0);
        mlast_d  = re_q && (coef_q == LAST);

        if (x_vld && (state_q != IDLE) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        unique case (state_q)
            CLEAR: begin
                // First cycle out of reset has no write yet, so the
                // index only advances once a write is on the port.
                if (we_q && (clr_idx_q == LAST)) begin
                    state_d = IDLE;
                    x_rdy_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    clr_idx_d = we_q ? clr_idx_q + AW'(1) : clr_idx_q;
                    we_d      = 1'b1;
                    waddr_d   = clr_idx_d;
                end
            end
            IDLE: begin
                if (x_vld) begin
                    state_d = WRITE;
                    we_d    = 1'b1;
                    waddr_d = wr_ptr_q;
                    wdata_d = x_data;
                end else begin
                    x_rdy_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            WRITE: begin
                state_d = RUN;
                k_d     = '0;
                re_d    = 1'b1;
                raddr_d = wr_ptr_q;
                coef_d  = '0;
            end
            RUN: begin
                if (k_q == LAST) begin
                    state_d = DRAIN;
                end else begin
                    k_d     = k_q + AW'(1);
                    re_d    = 1'b1;
                    coef_d  = k_d;
                    raddr_d = tap_addr(wr_ptr_q, k_d);
                end
            end
            DRAIN: begin
                state_d = DONE;
                yv_d    = 1'b1;
            end
            DONE: begin
                state_d  = IDLE;
                x_rdy_d  = 1'b1;
                busy_d   = 1'b0;
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + AW'(1);
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            clr_idx_q <= '0;
            k_q       <= '0;
            wr_ptr_q  <= '0;
            drop_q    <= '0;
            x_rdy_q   <= 1'b0;
            busy_q    <= 1'b1;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            re_q      <= 1'b0;
            raddr_q   <= '0;
            coef_q    <= '0;
            men_q     <= 1'b0;
            mfirst_q  <= 1'b0;
            mlast_q   <= 1'b0;
            yv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            k_q       <= k_d;
            wr_ptr_q  <= wr_ptr_d;
            drop_q    <= drop_d;
            x_rdy_q   <= x_rdy_d;
            busy_q    <= busy_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            re_q      <= re_d;
            raddr_q   <= raddr_d;
            coef_q    <= coef_d;
            men_q     <= men_d;
            mfirst_q  <= mfirst_d;
            mlast_q   <= mlast_d;
            yv_q      <= yv_d;
        end
    end

    assign x_rdy     = x_rdy_q;
    assign busy      = busy_q;
    assign dl_we     = we_q;
    assign dl_waddr  = waddr_q;
    assign dl_wdata  = wdata_q;
    assign dl_re     = re_q;
    assign dl_raddr  = raddr_q;
    assign coef_addr = coef_q;
    assign mac_en    = men_q;
    assign mac_first = mfirst_q;
    assign mac_last  = mlast_q;
    assign y_valid   = yv_q;
    assign drop_cnt  = drop_q;

endmodule

// File: doc/fir_serial_ctrl.md
Name: fir_serial_ctrl

Overview:
Sequencer for a full-serial FIR datapath: one delay-line RAM, one coefficient ROM and one MAC. It zero-fills the delay line after reset and accepts one input sample per strobe. For each sample it writes the delay line and then walks all taps, issuing RAM/ROM read addresses and MAC control aligned to a 1-cycle read latency, and finally pulses result-valid. It sits between the sample source (free-running, cannot stall) and the serial MAC datapath. Overruns are counted, not back-pressured.

Parameters:
TAPS, 16, number of filter taps (>=2; need not be a power of two); AW = $clog2(TAPS) is a localparam
DW, 12, sample width (two's complement)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
x_vld  in  1  single-cycle sample strobe
x_data  in  DW  sample, valid with x_vld
x_rdy  out  1  high only in IDLE; status, not a stall
dl_we  out  1  delay-line write enable
dl_waddr  out  AW  delay-line write address
dl_wdata  out  DW  delay-line write data
dl_re  out  1  delay-line/coef read enable (read data valid the next cycle)
dl_raddr  out  AW  delay-line read address
coef_addr  out  AW  coefficient ROM address
mac_en  out  1  MAC accumulate, aligned to read data
mac_first  out  1  with mac_en: load the product instead of accumulating
mac_last  out  1  with mac_en: final tap
y_valid  out  1  1-cycle pulse; MAC result register is valid
busy  out  1  state != IDLE
drop_cnt  out  16  samples lost (x_vld outside IDLE), saturates at 16'hFFFF

Behaviour:
- All outputs are registered. Reset: state=CLEAR, clear index=0, wr_ptr=0, drop_cnt=0, all strobes and addresses 0, x_rdy=0, busy=1.
- Reset asserted in any state, including mid-RUN, aborts the current operation. No y_valid is issued for the aborted sample, and CLEAR restarts.
- CLEAR: TAPS cycles with dl_we=1, dl_waddr=0..TAPS-1, dl_wdata=0. Then go to IDLE.
- IDLE: x_rdy=1, busy=0. If x_vld=1, capture x_data and go to WRITE (this cycle is T0).
- WRITE (T0+1): dl_we=1, dl_waddr=wr_ptr, dl_wdata=captured sample. Then k=0 and go to RUN.
- RUN (T0+2 .. T0+1+TAPS): dl_re=1, coef_addr=k, and dl_raddr=(wr_ptr-k) mod TAPS, computed as wr_ptr>=k ? wr_ptr-k : wr_ptr+TAPS-k. Increment k. After k=TAPS-1, go to DRAIN.
- MAC control is dl_re delayed 1 cycle: mac_en high T0+3 .. T0+2+TAPS, mac_first at T0+3 only, mac_last at T0+2+TAPS only.
- DRAIN (T0+2+TAPS): dl_re=0; carries the last mac_en/mac_last.
- DONE (T0+3+TAPS): y_valid=1. wr_ptr = (wr_ptr==TAPS-1) ? 0 : wr_ptr+1. Go to IDLE.
- Sample period: TAPS+4 cycles (20 for TAPS=16). x_rdy returns at T0+4+TAPS.
- x_vld in any state other than IDLE (CLEAR, WRITE, RUN, DRAIN, DONE): sample discarded and drop_cnt increments unless already 16'hFFFF. Accepted samples never increment drop_cnt.
- dl_we and dl_re are never high in the same cycle. mac_en is never high outside T0+3 .. T0+2+TAPS.

Test Plan:
- Reset: rst=1 for 3 cycles then 0 -> 16 cycles of dl_we=1 with waddr 0..15 and wdata 0; x_rdy=0 during those cycles, then x_rdy=1 on the next cycle; drop_cnt=0.
- First sample: x_vld with x_data=12'h7FF at T0 -> dl_we at T0+1 (addr 0, data 7FF); dl_raddr 0,15,14..1 and coef_addr 0..15 over T0+2..T0+17; mac_first at T0+3; mac_last at T0+18; y_valid at T0+19; x_rdy at T0+20.
- Wrap-around: feed 16 samples spaced 20 cycles -> the 5th writes addr 4 and reads 4,3,2,1,0,15..5; the 17th writes addr 0 again; no mac_en outside each sample's window.
- Overrun: strobes every 10 cycles for 20 strobes starting in IDLE -> 10 accepted, drop_cnt=10; preload drop_cnt=16'hFFFE, then 3 drops -> 16'hFFFF.
- Boundary strobes: x_vld in the DONE cycle -> dropped, drop_cnt+1; x_vld in the following IDLE cycle -> accepted, WRITE next cycle.
- Reset mid-RUN at T0+8 -> mac_en=0 from the next cycle; no y_valid; CLEAR rewrites addresses 0..15; wr_ptr=0; drop_cnt=0.
